// File: rtl/decode_buffer_rv32i_pkg.sv
`default_nettype none
// =============================================================================
// Module      : decode_buffer_rv32i_pkg
// Description : Shared RV32I opcodes, immediate-type codes, buffer states, types.
// Revision    : 1.0
// =============================================================================
package decode_buffer_rv32i_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [24:0] trimmed;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [2:0]  immtype;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        dec_t        dec;
        logic [31:0] pc;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_decode_rv32i.sv
`default_nettype none
// =============================================================================
// Module      : instr_decode_rv32i
// Description : Combinational RV32I field extraction and immediate-type decode.
// Revision    : 1.0
// =============================================================================
module instr_decode_rv32i
    import decode_buffer_rv32i_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    always_comb begin
        o_dec.trimmed = i_instr[31:7];
        o_dec.opcode  = i_instr[6:0];
        o_dec.rd      = i_instr[11:7];
        o_dec.funct3  = i_instr[14:12];
        o_dec.rs1     = i_instr[19:15];
        o_dec.rs2     = i_instr[24:20];
        o_dec.funct7  = i_instr[31:25];
        o_dec.immtype = IMM_NONE;
        o_dec.illegal = 1'b0;
        // Every listed opcode ends in 2'b11, so a bad low pair lands in default.
        case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: o_dec.immtype = IMM_I;
            OP_STORE:                                      o_dec.immtype = IMM_S;
            OP_BRANCH:                                     o_dec.immtype = IMM_B;
            OP_LUI, OP_AUIPC:                              o_dec.immtype = IMM_U;
            OP_JAL:                                        o_dec.immtype = IMM_J;
            OP_REG:                                        o_dec.immtype = IMM_NONE;
            default:                                       o_dec.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_buffer_rv32i.sv
`default_nettype none
// =============================================================================
// Module      : decode_buffer_rv32i
// Description : RV32I decode stage with a 2-entry in-order skid buffer.
// Revision    : 1.0
// =============================================================================
module decode_buffer_rv32i
    import decode_buffer_rv32i_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [24:0] trimmed_instr,
    output logic [2:0]  cu_immtype,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic        illegal
);

    buf_state_t r_state;
    buf_state_t w_state_next;
    logic       r_in_ready;
    entry_t     r_head;
    entry_t     r_tail;
    entry_t     w_in_entry;
    entry_t     w_out;
    dec_t       w_dec;
    logic       w_out_valid;
    logic       w_accept;
    logic       w_consume;
    logic       w_load_head_in;
    logic       w_load_head_tail;
    logic       w_load_tail;

    instr_decode_rv32i u_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign w_in_entry  = '{dec: w_dec, pc: in_pc};
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid && r_in_ready;
    assign w_consume   = w_out_valid && out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_tail = 1'b0;
        w_load_tail      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next   = ST_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_FULL;
                        w_load_tail  = 1'b1;
                    end else if (w_consume) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        w_state_next     = ST_ONE;
                        w_load_head_tail = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // in_ready is a flop derived from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_in_entry;
            end else if (w_load_head_tail) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_in_entry;
            end
        end
    end

    assign w_out         = w_out_valid ? r_head : '0;
    assign in_ready      = r_in_ready;
    assign out_valid     = w_out_valid;
    assign out_pc        = w_out.pc;
    assign trimmed_instr = w_out.dec.trimmed;
    assign cu_immtype    = w_out.dec.immtype;
    assign opcode        = w_out.dec.opcode;
    assign rd            = w_out.dec.rd;
    assign funct3        = w_out.dec.funct3;
    assign rs1           = w_out.dec.rs1;
    assign rs2           = w_out.dec.rs2;
    assign funct7        = w_out.dec.funct7;
    assign illegal       = w_out.dec.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_buffer_rv32i.sv
`default_nettype none
// =============================================================================
// Module      : tb_decode_buffer_rv32i
// Description : Directed scoreboard bench for the RV32I decode skid buffer.
// Revision    : 1.0
// =============================================================================
module tb_decode_buffer_rv32i;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [24:0] trimmed_instr;
    logic [2:0]  cu_immtype;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        illegal;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   last_accept;
    int   acc_count;

    always #5 clock = ~clock;

    decode_buffer_rv32i dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .trimmed_instr (trimmed_instr),
        .cu_immtype    (cu_immtype),
        .opcode        (opcode),
        .rd            (rd),
        .funct3        (funct3),
        .rs1           (rs1),
        .rs2           (rs2),
        .funct7        (funct7),
        .illegal       (illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {illegal, immtype} for an instruction word.
    function automatic logic [3:0] model_imm(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 4'b1111;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return 4'b0000;
            7'h23:                             return 4'b0001;
            7'h63:                             return 4'b0010;
            7'h37, 7'h17:                      return 4'b0011;
            7'h6F:                             return 4'b0100;
            7'h33:                             return 4'b0111;
            default:                           return 4'b1111;
        endcase
    endfunction

    task automatic compare_head(input exp_t e);
        logic [3:0] m;
        m = model_imm(e.instr);
        chk("out_pc",  out_pc,        e.pc);
        chk("trimmed", trimmed_instr, e.instr >> 7);
        chk("opcode",  opcode,        e.instr & 32'h7F);
        chk("rd",      rd,            (e.instr >> 7) & 32'h1F);
        chk("funct3",  funct3,        (e.instr >> 12) & 32'h7);
        chk("rs1",     rs1,           (e.instr >> 15) & 32'h1F);
        chk("rs2",     rs2,           (e.instr >> 20) & 32'h1F);
        chk("funct7",  funct7,        e.instr >> 25);
        chk("immtype", cu_immtype,    m[2:0]);
        chk("illegal", illegal,       m[3]);
    endtask

    // One clock cycle: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clock);
        last_accept = in_valid && in_ready;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                chk("out_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    compare_head(sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_queue_empty", sb.size(), 0);
                chk("idle_pc", out_pc, 0);
                chk("idle_fields", {trimmed_instr, cu_immtype, opcode, rd, funct3,
                                    rs1, rs2, funct7, illegal}, 0);
            end
            if (last_accept) sb.push_back('{in_pc, in_instr});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        step();
    endtask

    logic [31:0] tbl [11] = '{32'h000000B7, 32'h00000117, 32'h0040006F, 32'h00208463,
                              32'h002081B3, 32'h00012083, 32'h000080E7, 32'h0000000F,
                              32'h00000073, 32'h00000091, 32'h0000005B};

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_pc",    out_pc,    0);
        reset = 1'b0;

        // First instruction straight after reset, one-cycle latency.
        out_ready = 1'b1;
        push(32'h0, 32'h00500093);
        chk("accept_after_reset", last_accept, 1);
        in_valid = 1'b0;
        chk("lat_out_valid", out_valid,     1);
        chk("addi_imm",      cu_immtype,    3'b000);
        chk("addi_trimmed",  trimmed_instr, 25'h000A001);
        chk("addi_rd",       rd,            1);
        chk("addi_rs1",      rs1,           0);
        chk("addi_illegal",  illegal,       0);
        step();

        push(32'h4, 32'h00112623);
        in_valid = 1'b0;
        chk("sw_imm",    cu_immtype, 3'b001);
        chk("sw_rs1",    rs1,        2);
        chk("sw_rs2",    rs2,        1);
        chk("sw_funct3", funct3,     3'b010);
        step();

        push(32'h8, 32'h00000000);
        in_valid = 1'b0;
        chk("zero_illegal", illegal,    1);
        chk("zero_imm",     cu_immtype, 3'b111);
        step();

        // Back-to-back throughput over all opcode classes.
        acc_count = 0;
        for (int i = 0; i < 11; i++) begin
            push(32'h100 + 32'(i) * 4, tbl[i]);
            acc_count += int'(last_accept);
        end
        chk("throughput", acc_count, 11);
        drain();

        // Backpressure: two accepted, third waits until space frees.
        out_ready = 1'b0;
        push(32'h0, 32'h00A00113);
        chk("bp_ready_one", in_ready, 1);
        push(32'h4, 32'h00B00193);
        chk("bp_ready_full", in_ready,  0);
        chk("bp_valid_full", out_valid, 1);
        push(32'h8, 32'h00C00213);
        chk("bp_no_accept_full", last_accept, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (last_accept) break;
        end
        chk("bp_accept_third", last_accept, 1);
        in_valid = 1'b0;
        drain();

        // Flush from FULL with a simultaneous input.
        out_ready = 1'b0;
        push(32'h200, 32'h00100093);
        push(32'h204, 32'h00200093);
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        push(32'h208, 32'h00300093);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready",  in_ready,  1);
        out_ready = 1'b1;
        repeat (3) step();

        // Flush from ONE while in_ready=1: the offered input is dropped.
        out_ready = 1'b0;
        push(32'h300, 32'h00400093);
        flush = 1'b1;
        push(32'h304, 32'h00500093);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 1'b0;
        push(32'h400, 32'h00600093);
        push(32'h404, 32'h00700093);
        in_valid = 1'b0;
        chk("ar_full", in_ready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready",  in_ready,  1);
        chk("ar_out_pc",    out_pc,    0);
        chk("ar_fields", {trimmed_instr, cu_immtype, opcode, rd, funct3,
                          rs1, rs2, funct7, illegal}, 0);
        sb.delete();
        #2;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        in_instr  = 32'h00800093;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("ar_first_accept", out_valid, 1);
        chk("ar_first_pc",     out_pc,    32'h500);
        sb.push_back('{32'h500, 32'h00800093});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
